imem_loader: RTL

//  Byte-stream writer that fills instruction memory before the core runs: accepts a framed

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_byte_packer.sv | 45 ++++
 rtl/imem_loader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the instruction-memory loader.
// The optional trailing checksum is enabled by defining LOADER_CHECKSUM_EN.
package imem_loader_pkg;

   localparam int LOADER_DEPTH = 64;
   localparam int LOADER_AW    = 6;
   localparam int LOADER_IDX_W = 2;

   typedef enum logic [2:0] {
      HDR   = 3'd0,
      DATA  = 3'd1,
      CHECK = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } loader_state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes MSB-first into 32-bit words and pulses word_valid
// in the same cycle the fourth byte of a word is accepted.
module imem_loader_byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [LOADER_IDX_W-1:0] idx_q, idx_d;
   // only the first three bytes of a word need storing; the fourth arrives live
   logic [23:0]             shift_q, shift_d;

   // next byte index and shift contents
   always_comb begin
      idx_d   = idx_q;
      shift_d = shift_q;
      if (byte_valid) begin
         idx_d   = idx_q + 2'd1;
         shift_d = {shift_q[15:0], byte_data};
      end else begin
         idx_d   = idx_q;
         shift_d = shift_q;
      end
   end

   assign word_valid = byte_valid && (idx_q == 2'd3);
   assign word       = {shift_q, byte_data};

   // packer state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q   <= '0;
         shift_q <= 24'h000000;
      end else begin
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory; holds the core in reset
// until a full image is written. Checksum byte enabled by LOADER_CHECKSUM_EN.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH = LOADER_DEPTH,
   parameter int AW    = LOADER_AW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [7:0]    in_data,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic          cpu_reset,
   output logic          load_done,
   output logic          load_err,
   output logic [AW:0]   word_count
);

   localparam logic [AW:0] ONE_W = {{AW{1'b0}}, 1'b1};

   loader_state_e state_q, state_d;
   logic [AW:0]   n_q, n_d, wc_q, wc_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic          mem_we_q, mem_we_d, in_ready_q, in_ready_d;
   logic          cpu_reset_q, cpu_reset_d, load_done_q, load_done_d;
   logic          load_err_q, load_err_d;
   logic          accept_s, word_valid_s;
   logic [31:0]   word_s;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]    chk_q, chk_d;
`endif

   assign accept_s = in_valid && in_ready_q;

   imem_loader_byte_packer u_packer (
      .clk        (clk),
      .rst_n      (reset),
      .byte_valid (accept_s && (state_q == DATA)),
      .byte_data  (in_data),
      .word_valid (word_valid_s),
      .word       (word_s)
   );

   // frame sequencing, write strobe and status next-state
   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      wc_d        = wc_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
      chk_d       = chk_q;
`endif
      case (state_q)
         HDR: begin
            if (accept_s) begin
               if ((in_data == 8'd0) || (in_data > 8'(DEPTH))) begin
                  state_d = ERR;
               end else begin
                  n_d     = in_data[AW:0];
                  state_d = DATA;
               end
            end else begin
               state_d = HDR;
            end
         end
         DATA: begin
`ifdef LOADER_CHECKSUM_EN
            if (accept_s) begin
               chk_d = chk_q ^ in_data;
            end else begin
               chk_d = chk_q;
            end
`endif
            if (word_valid_s) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = wc_q[AW-1:0];
               mem_wdata_d = word_s;
               wc_d        = wc_q + ONE_W;
               if ((wc_q + ONE_W) == n_q) begin
`ifdef LOADER_CHECKSUM_EN
                  state_d = CHECK;
`else
                  state_d = DONE;
`endif
               end else begin
                  state_d = DATA;
               end
            end else begin
               state_d = DATA;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CHECK: begin
            if (accept_s) begin
               state_d = (in_data == chk_q) ? DONE : ERR;
            end else begin
               state_d = CHECK;
            end
         end
`endif
         DONE:    state_d = DONE;
         ERR:     state_d = ERR;
         default: state_d = ERR;
      endcase
      in_ready_d  = (state_d == HDR) || (state_d == DATA) || (state_d == CHECK);
      load_done_d = (state_d == DONE);
      load_err_d  = (state_d == ERR);
      // release the core only once DONE has been held a cycle, so the last write lands first
      cpu_reset_d = (state_q != DONE);
   end

   // loader state and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= HDR;
         n_q         <= '0;
         wc_q        <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'h0000_0000;
         in_ready_q  <= 1'b0;
         cpu_reset_q <= 1'b1;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         chk_q       <= 8'h00;
`endif
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         wc_q        <= wc_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         in_ready_q  <= in_ready_d;
         cpu_reset_q <= cpu_reset_d;
         load_done_q <= load_done_d;
         load_err_q  <= load_err_d;
`ifdef LOADER_CHECKSUM_EN
         chk_q       <= chk_d;
`endif
      end
   end

   assign in_ready   = in_ready_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign cpu_reset  = cpu_reset_q;
   assign load_done  = load_done_q;
   assign load_err   = load_err_q;
   assign word_count = wc_q;

endmodule
